// File: rtl/fp_div_seq.sv
// Request/response sequencer in front of the iterative fp_div core: one op in flight,
// registered divider interface, wait-for-done with timeout, and flush abort.
module fp_div_seq #(
  parameter int unsigned FP_WIDTH       = 32,
  parameter int unsigned RND_WIDTH      = 3,
  parameter int unsigned RES_WIDTH      = 37,
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [FP_WIDTH-1:0]  req_a_i,
  input  logic [FP_WIDTH-1:0]  req_b_i,
  input  logic [RND_WIDTH-1:0] req_rnd_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  output logic [FP_WIDTH-1:0]  div_a_o,
  output logic [FP_WIDTH-1:0]  div_b_o,
  output logic [RND_WIDTH-1:0] div_rnd_o,
  output logic                 div_start_o,
  input  logic                 div_done_i,
  input  logic [RES_WIDTH-1:0] div_res_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [RES_WIDTH-1:0] rsp_res_o,
  output logic [TAG_WIDTH-1:0] rsp_tag_o,
  output logic                 rsp_timeout_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

  state_e               state_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [TAG_WIDTH-1:0] tag_reg;
  logic                 accept;

  // A response slot freed this cycle can take the next op immediately; flush blocks acceptance.
  assign req_ready_o = ~rst_i & ~flush_i &
                       ((state_reg == IDLE) | ((state_reg == RESP) & rsp_ready_i));
  assign accept      = req_valid_i & req_ready_o;
  assign busy_o      = (state_reg != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      tag_reg       <= '0;
      div_a_o       <= '0;
      div_b_o       <= '0;
      div_rnd_o     <= '0;
      div_start_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_res_o     <= '0;
      rsp_tag_o     <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      div_start_o <= 1'b0;
      if (flush_i) begin
        state_reg   <= IDLE;
        rsp_valid_o <= 1'b0;
        cnt_reg     <= '0;
      end else if (accept) begin
        div_a_o     <= req_a_i;
        div_b_o     <= req_b_i;
        div_rnd_o   <= req_rnd_i;
        tag_reg     <= req_tag_i;
        div_start_o <= 1'b1;
        rsp_valid_o <= 1'b0;
        state_reg   <= START;
      end else begin
        case (state_reg)
          START: begin
            cnt_reg   <= '0;
            state_reg <= WAIT;
          end
          WAIT: begin
            // A done arriving on the last allowed cycle still wins over the timeout.
            if (div_done_i) begin
              rsp_res_o     <= div_res_i;
              rsp_tag_o     <= tag_reg;
              rsp_timeout_o <= 1'b0;
              rsp_valid_o   <= 1'b1;
              state_reg     <= RESP;
            end else if (cnt_reg == CNT_LAST) begin
              rsp_res_o     <= '0;
              rsp_tag_o     <= tag_reg;
              rsp_timeout_o <= 1'b1;
              rsp_valid_o   <= 1'b1;
              state_reg     <= RESP;
            end else begin
              cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            end
          end
          RESP: begin
            if (rsp_ready_i) begin
              rsp_valid_o <= 1'b0;
              state_reg   <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
